// File: rtl/spi_byte_receiver.sv
// SPI mode-0 slave front end, MSB first, oversampled by the system clock.
// Assembles bytes from mosi, presents each one on rx_data with a held rdy
// strobe for the downstream edge detector, echoes the previous byte on miso,
// and reports framing errors (partial byte at cs_n rise) and overruns.
module spi_byte_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int RDY_HOLD    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frame_active,
  output logic       frame_err,
  output logic       overrun
);

  // Hold counter counts RDY_HOLD-1 down to 0, so it needs clog2(RDY_HOLD) bits.
  localparam int HOLD_W = (RDY_HOLD > 2) ? $clog2(RDY_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RDY_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_n_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_s;
  logic                   cs_n_s;
  logic                   mosi_s;
  logic                   sclk_s_p1;
  logic                   cs_n_s_p1;
  logic                   sclk_rise;
  logic                   sclk_fall;
  logic                   cs_fall;
  logic [2:0]             bit_cnt;
  logic [6:0]             rx_shift;
  logic [7:0]             rx_byte;
  logic [7:0]             tx_shift;
  logic [7:0]             tx_next;
  logic [7:0]             echo_reg;
  logic [HOLD_W-1:0]      hold_cnt;

  // Synchronizer chains for the asynchronous SPI pins plus one stage of history for edge detection
  always_ff @(posedge clk) begin
    if (!reset) begin
      sclk_sync <= '0;
      cs_n_sync <= '1;
      mosi_sync <= '0;
      sclk_s_p1 <= 1'b0;
      cs_n_s_p1 <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_n_sync <= {cs_n_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_s_p1 <= sclk_s;
      cs_n_s_p1 <= cs_n_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_n_s    = cs_n_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];

  // sclk edges only count while the slave is selected
  assign sclk_rise = ~cs_n_s & sclk_s & ~sclk_s_p1;
  assign sclk_fall = ~cs_n_s & ~sclk_s & sclk_s_p1;
  assign cs_fall   = ~cs_n_s & cs_n_s_p1;
  assign rx_byte   = {rx_shift, mosi_s};

  // Next transmit word on an sclk fall: reload the echo at a byte boundary, otherwise shift
  always_comb begin
    tx_next = {tx_shift[6:0], 1'b0};
    if (bit_cnt == 3'd0) tx_next = echo_reg;
  end

  // Frame FSM with byte assembly, echo shifter, rdy hold timer and error flags
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      bit_cnt      <= 3'd0;
      rx_shift     <= 7'd0;
      tx_shift     <= 8'h00;
      echo_reg     <= 8'h00;
      hold_cnt     <= '0;
      rx_data      <= 8'h00;
      rdy          <= 1'b0;
      frame_active <= 1'b0;
      frame_err    <= 1'b0;
      overrun      <= 1'b0;
      miso         <= 1'b0;
    end else begin
      overrun      <= 1'b0;
      frame_active <= ~cs_n_s;

      if (rdy) begin
        if (hold_cnt == '0) rdy <= 1'b0;
        else                hold_cnt <= hold_cnt - HOLD_ONE;
      end

      case (state)
        IDLE: begin
          miso <= 1'b0;
          if (cs_fall) begin
            state     <= SHIFT;
            bit_cnt   <= 3'd0;
            frame_err <= 1'b0;
            tx_shift  <= echo_reg;
            miso      <= echo_reg[7];
          end
        end
        SHIFT: begin
          if (cs_n_s) begin
            state   <= IDLE;
            bit_cnt <= 3'd0;
            miso    <= 1'b0;
            if (bit_cnt != 3'd0) frame_err <= 1'b1;
          end else begin
            if (sclk_rise) begin
              rx_shift <= rx_byte[6:0];
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rx_data  <= rx_byte;
                echo_reg <= rx_byte;
                rdy      <= 1'b1;
                hold_cnt <= HOLD_INIT;
                overrun  <= rdy;
              end
            end
            if (sclk_fall) begin
              tx_shift <= tx_next;
              miso     <= tx_next[7];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_byte_receiver.sv
// Directed bench for spi_byte_receiver: four instances share one SPI stimulus
// (default, RDY_HOLD=40, RDY_HOLD=80, SYNC_STAGES=3) and are checked per scenario.
module tb_spi_byte_receiver;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic sclk = 1'b0;
  logic cs_n = 1'b1;
  logic mosi = 1'b0;

  logic       miso_v [4];
  logic [7:0] rx_data_v [4];
  logic [3:0] rdy_v;
  logic [3:0] act_v;
  logic [3:0] ferr_v;
  logic [3:0] ovr_v;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int set_cyc = 0;
  logic [7:0] miso_byte = 8'h00;

  int rise_cnt [4] = '{default: 0};
  int fall_cnt [4] = '{default: 0};
  int ovr_cnt  [4] = '{default: 0};
  int last_rise[4] = '{default: 0};
  int cur_len  [4] = '{default: 0};
  int last_len [4] = '{default: 0};
  logic [3:0] rdy_prev = 4'b0;

  int base_rise [4];
  int base_fall [4];
  int base_ovr  [4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_byte_receiver #(.SYNC_STAGES(2), .RDY_HOLD(4)) u_dflt (
    .clk(clk), .reset(reset), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso_v[0]), .rx_data(rx_data_v[0]), .rdy(rdy_v[0]),
    .frame_active(act_v[0]), .frame_err(ferr_v[0]), .overrun(ovr_v[0]));

  spi_byte_receiver #(.SYNC_STAGES(2), .RDY_HOLD(40)) u_h40 (
    .clk(clk), .reset(reset), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso_v[1]), .rx_data(rx_data_v[1]), .rdy(rdy_v[1]),
    .frame_active(act_v[1]), .frame_err(ferr_v[1]), .overrun(ovr_v[1]));

  spi_byte_receiver #(.SYNC_STAGES(2), .RDY_HOLD(80)) u_h80 (
    .clk(clk), .reset(reset), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso_v[2]), .rx_data(rx_data_v[2]), .rdy(rdy_v[2]),
    .frame_active(act_v[2]), .frame_err(ferr_v[2]), .overrun(ovr_v[2]));

  spi_byte_receiver #(.SYNC_STAGES(3), .RDY_HOLD(4)) u_s3 (
    .clk(clk), .reset(reset), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso_v[3]), .rx_data(rx_data_v[3]), .rdy(rdy_v[3]),
    .frame_active(act_v[3]), .frame_err(ferr_v[3]), .overrun(ovr_v[3]));

  // rdy pulse and overrun bookkeeping, sampled on the inactive edge
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rdy_v[i] && !rdy_prev[i]) begin
        rise_cnt[i]  <= rise_cnt[i] + 1;
        last_rise[i] <= cyc;
        cur_len[i]   <= 1;
      end else if (rdy_v[i]) begin
        cur_len[i] <= cur_len[i] + 1;
      end
      if (!rdy_v[i] && rdy_prev[i]) begin
        fall_cnt[i] <= fall_cnt[i] + 1;
        last_len[i] <= cur_len[i];
      end
      if (ovr_v[i]) ovr_cnt[i] <= ovr_cnt[i] + 1;
    end
    rdy_prev <= rdy_v;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    for (int i = 0; i < 4; i++) begin
      base_rise[i] = rise_cnt[i];
      base_fall[i] = fall_cnt[i];
      base_ovr[i]  = ovr_cnt[i];
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    sclk  = 1'b0;
    cs_n  = 1'b1;
    mosi  = 1'b0;
    wait_clk(3);
    reset = 1'b1;
    wait_clk(4);
  endtask

  task automatic start_frame();
    cs_n = 1'b0;
    wait_clk(6);
  endtask

  task automatic end_frame();
    wait_clk(4);
    cs_n = 1'b1;
    wait_clk(8);
  endtask

  // Mode 0: data set while sclk low, slave samples on the rise; miso captured at the rise
  task automatic send_bits(input logic [7:0] data, input int nbits, input int half);
    logic [7:0] d;
    d = data;
    miso_byte = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = d[7-i];
      wait_clk(half);
      sclk = 1'b1;
      miso_byte = {miso_byte[6:0], miso_v[0]};
      set_cyc = cyc;
      wait_clk(half);
      sclk = 1'b0;
    end
  endtask

  initial begin
    // Scenario 1: reset values, then a single 8'hA5 at sclk period 16
    do_reset();
    snap();
    check("rst_rx_data", rx_data_v[0], 8'h00);
    check("rst_rdy", rdy_v[0], 1'b0);
    check("rst_frame_active", act_v[0], 1'b0);
    check("rst_frame_err", ferr_v[0], 1'b0);
    check("rst_overrun", ovr_v[0], 1'b0);
    check("rst_miso", miso_v[0], 1'b0);
    start_frame();
    check("s1_frame_active", act_v[0], 1'b1);
    send_bits(8'hA5, 8, 8);
    wait_clk(10);
    check("s1_rx_data", rx_data_v[0], 8'hA5);
    check("s1_rdy_pulses", rise_cnt[0] - base_rise[0], 1);
    check("s1_rdy_len", last_len[0], 4);
    check("s1_rdy_latency", last_rise[0] - set_cyc, 3);
    check("s1_miso", miso_byte, 8'h00);
    check("s1_frame_err", ferr_v[0], 1'b0);
    end_frame();
    check("s1_frame_idle", act_v[0], 1'b0);

    // Scenario 2: three back-to-back bytes, echo lags by one byte
    do_reset();
    snap();
    start_frame();
    send_bits(8'h55, 8, 8);
    check("s2_rx0", rx_data_v[0], 8'h55);
    check("s2_miso0", miso_byte, 8'h00);
    send_bits(8'h3C, 8, 8);
    check("s2_rx1", rx_data_v[0], 8'h3C);
    check("s2_miso1", miso_byte, 8'h55);
    send_bits(8'hFF, 8, 8);
    check("s2_rx2", rx_data_v[0], 8'hFF);
    check("s2_miso2", miso_byte, 8'h3C);
    end_frame();
    check("s2_rdy_pulses", rise_cnt[0] - base_rise[0], 3);
    check("s2_overrun", ovr_cnt[0] - base_ovr[0], 0);

    // Scenario 3: partial byte then cs_n rise, followed by a clean frame
    snap();
    start_frame();
    send_bits(8'hF0, 5, 8);
    end_frame();
    check("s3_no_rdy", rise_cnt[0] - base_rise[0], 0);
    check("s3_rx_hold", rx_data_v[0], 8'hFF);
    check("s3_frame_err", ferr_v[0], 1'b1);
    start_frame();
    check("s3_err_clear", ferr_v[0], 1'b0);
    send_bits(8'h12, 8, 8);
    wait_clk(6);
    check("s3_rx_next", rx_data_v[0], 8'h12);
    check("s3_miso_echo", miso_byte, 8'hFF);
    end_frame();
    check("s3_err_after", ferr_v[0], 1'b0);

    // Scenario 4: long rdy hold with 64-clk bytes
    do_reset();
    snap();
    start_frame();
    send_bits(8'h11, 8, 4);
    send_bits(8'h22, 8, 4);
    check("s4_h40_ovr", ovr_cnt[1] - base_ovr[1], 0);
    check("s4_h40_falls", fall_cnt[1] - base_fall[1], 1);
    check("s4_h40_rx", rx_data_v[1], 8'h22);
    check("s4_h80_ovr", ovr_cnt[2] - base_ovr[2], 1);
    check("s4_h80_falls", fall_cnt[2] - base_fall[2], 0);
    check("s4_h80_rdy", rdy_v[2], 1'b1);
    check("s4_h80_rx", rx_data_v[2], 8'h22);
    end_frame();

    // Scenario 5: reset in the middle of a byte
    start_frame();
    send_bits(8'hFF, 4, 8);
    reset = 1'b0;
    cs_n  = 1'b1;
    wait_clk(3);
    check("s5_rst_rx", rx_data_v[0], 8'h00);
    check("s5_rst_rdy", rdy_v[0], 1'b0);
    check("s5_rst_act", act_v[0], 1'b0);
    check("s5_rst_ferr", ferr_v[0], 1'b0);
    check("s5_rst_miso", miso_v[0], 1'b0);
    check("s5_rst_h80_rdy", rdy_v[2], 1'b0);
    reset = 1'b1;
    wait_clk(8);
    snap();
    start_frame();
    send_bits(8'h81, 8, 8);
    wait_clk(6);
    check("s5_rx", rx_data_v[0], 8'h81);
    check("s5_rdy_pulses", rise_cnt[0] - base_rise[0], 1);
    check("s5_miso", miso_byte, 8'h00);
    end_frame();
    check("s5_frame_err", ferr_v[0], 1'b0);

    // Scenario 6: three-stage synchronizer at minimum sclk phases
    do_reset();
    snap();
    start_frame();
    send_bits(8'h69, 8, 4);
    wait_clk(6);
    check("s6_s3_rx", rx_data_v[3], 8'h69);
    check("s6_s3_latency", last_rise[3] - set_cyc, 4);
    check("s6_s3_rdy_len", last_len[3], 4);
    check("s6_dflt_rx", rx_data_v[0], 8'h69);
    check("s6_dflt_latency", last_rise[0] - set_cyc, 3);
    end_frame();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
